msg_tx_framer: RTL and testbench

//  Transmit-side framer for the AXI-Stream message path. Takes a message length in bytes on a

---
 rtl/msg_tx_framer.sv | 128 ++++++++++++
 tb/tb_msg_tx_framer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/msg_tx_framer.sv
// AXI-Stream transmit framer: turns a byte-length command into payload beats with exact tkeep/tlast.
// Optional length header beat ahead of the payload when MSG_TX_LEN_HDR_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a command; all stream outputs low
//   HDR   | emitting the length header beat (MSG_TX_LEN_HDR_EN only)
//   DATA  | passing payload beats through, counting rem down per beat
module msg_tx_framer #(
    parameter int          TKEEP_WIDTH = 8,
    parameter logic [15:0] MAX_LEN     = 16'd9000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_length,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [8*TKEEP_WIDTH-1:0] s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [8*TKEEP_WIDTH-1:0] m_tdata,
    output logic [TKEEP_WIDTH-1:0]   m_tkeep,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     len_err
);

    localparam logic [15:0] W16 = 16'(TKEEP_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef MSG_TX_LEN_HDR_EN
        HDR  = 2'd1,
`endif
        DATA = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [15:0]            rem, rem_nxt;
    logic                   len_err_nxt;
    logic                   len_bad;
    logic [TKEEP_WIDTH-1:0] beat_keep;

    assign len_bad = (cmd_length == 16'd0) || (cmd_length > MAX_LEN);
    assign busy    = (state != IDLE);

    // Byte i is valid while more than i bytes remain; saturates to all ones for full beats.
    always_comb begin
        beat_keep = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            beat_keep[i] = (rem > 16'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rem     <= 16'd0;
            len_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            len_err <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        len_err_nxt = 1'b0;
        cmd_ready   = 1'b0;
        s_tready    = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tkeep     = '0;
        m_tlast     = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (len_bad) begin
                        len_err_nxt = 1'b1;
                    end else begin
                        rem_nxt = cmd_length;
`ifdef MSG_TX_LEN_HDR_EN
                        state_nxt = HDR;
`else
                        state_nxt = DATA;
`endif
                    end
                end
            end
`ifdef MSG_TX_LEN_HDR_EN
            // rem still holds the full command length here, so it doubles as the header payload.
            HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = {{(8*TKEEP_WIDTH-16){1'b0}}, rem};
                m_tkeep  = {{(TKEEP_WIDTH-2){1'b0}}, 2'b11};
                if (m_tready) begin
                    state_nxt = DATA;
                end
            end
`endif
            DATA: begin
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                m_tdata  = s_tdata;
                m_tkeep  = beat_keep;
                m_tlast  = (rem <= W16);
                if (s_tvalid && m_tready) begin
                    if (rem <= W16) begin
                        state_nxt = IDLE;
                        rem_nxt   = 16'd0;
                    end else begin
                        rem_nxt = rem - W16;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_msg_tx_framer.sv
// Directed bench for msg_tx_framer (TKEEP_WIDTH=8); inputs driven and outputs sampled on the falling edge.
// Define MSG_TX_LEN_HDR_EN to exercise the header-beat build.
module tb_msg_tx_framer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_length;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        busy;
    logic        len_err;

    int n_tests = 0;
    int n_fail  = 0;

    msg_tx_framer #(.TKEEP_WIDTH(8), .MAX_LEN(16'd9000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .busy(busy), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".m_tvalid"},  64'(m_tvalid),  64'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the command is taken.
    task automatic send_cmd(input string tag, input logic [15:0] len);
        cmd_valid  = 1'b1;
        cmd_length = len;
        #1;
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk({tag, ".busy"},      64'(busy),      64'd1);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd0);
`ifdef MSG_TX_LEN_HDR_EN
        chk({tag, ".hdr_tvalid"}, 64'(m_tvalid),      64'd1);
        chk({tag, ".hdr_tdata"},  64'(m_tdata[15:0]), 64'(len));
        chk({tag, ".hdr_tkeep"},  64'(m_tkeep),       64'h03);
        chk({tag, ".hdr_tlast"},  64'(m_tlast),       64'd0);
        chk({tag, ".hdr_sready"}, 64'(s_tready),      64'd0);
        @(negedge clk);
`endif
    endtask

    task automatic beat(input string tag, input logic [63:0] d,
                        input logic [7:0] exp_keep, input logic exp_last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        #1;
        chk({tag, ".tvalid"}, 64'(m_tvalid), 64'd1);
        chk({tag, ".tdata"},  m_tdata,       d);
        chk({tag, ".tkeep"},  64'(m_tkeep),  64'(exp_keep));
        chk({tag, ".tlast"},  64'(m_tlast),  64'(exp_last));
        chk({tag, ".sready"}, 64'(s_tready), 64'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_bad(input string tag, input logic [15:0] len);
        cmd_valid  = 1'b1;
        cmd_length = len;
        #1;
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk({tag, ".len_err"}, 64'(len_err), 64'd1);
        chk_idle({tag, ".after"});
        @(negedge clk);
        #1;
        chk({tag, ".len_err_clr"}, 64'(len_err), 64'd0);
        chk({tag, ".m_tvalid2"},   64'(m_tvalid), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_length = 16'd0;
        s_tvalid   = 1'b0;
        s_tdata    = 64'd0;
        m_tready   = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset.m_tdata",  m_tdata,        64'd0);
        chk("reset.m_tkeep",  64'(m_tkeep),   64'd0);
        chk("reset.m_tlast",  64'(m_tlast),   64'd0);
        chk("reset.s_tready", 64'(s_tready),  64'd0);
        chk("reset.len_err",  64'(len_err),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // len=20: 8+8+4 bytes
        send_cmd("t1.cmd", 16'd20);
        beat("t1.b1", 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        beat("t1.b2", 64'h5555_6666_7777_8888, 8'hFF, 1'b0);
        beat("t1.b3", 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1);
        #1;
        chk_idle("t1.done");
        @(negedge clk);

        // exact multiple, then single byte
        send_cmd("t2a.cmd", 16'd16);
        beat("t2a.b1", 64'h0102_0304_0506_0708, 8'hFF, 1'b0);
        beat("t2a.b2", 64'h1112_1314_1516_1718, 8'hFF, 1'b1);
        #1;
        chk_idle("t2a.done");
        @(negedge clk);
        send_cmd("t2b.cmd", 16'd1);
        beat("t2b.b1", 64'hDEAD_BEEF_CAFE_F00D, 8'h01, 1'b1);
        #1;
        chk_idle("t2b.done");
        @(negedge clk);

        // illegal lengths, including the first one past MAX_LEN; 9000 itself is legal
        send_bad("t3.len0", 16'd0);
        send_bad("t3.len9001", 16'd9001);
        send_cmd("t3.max", 16'd9000);
        chk("t3.max.tkeep", 64'(m_tkeep), 64'hFF);
        chk("t3.max.tlast", 64'(m_tlast), 64'd0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);

        // len=24 with a 3-cycle stall on beat 2
        send_cmd("t4.cmd", 16'd24);
        beat("t4.b1", 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 64'hB0B1_B2B3_B4B5_B6B7;
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4.stall.tvalid", 64'(m_tvalid), 64'd1);
            chk("t4.stall.tdata",  m_tdata,       64'hB0B1_B2B3_B4B5_B6B7);
            chk("t4.stall.tkeep",  64'(m_tkeep),  64'hFF);
            chk("t4.stall.tlast",  64'(m_tlast),  64'd0);
            chk("t4.stall.sready", 64'(s_tready), 64'd0);
            @(negedge clk);
        end
        m_tready = 1'b1;
        beat("t4.b2", 64'hB0B1_B2B3_B4B5_B6B7, 8'hFF, 1'b0);
        beat("t4.b3", 64'hC0C1_C2C3_C4C5_C6C7, 8'hFF, 1'b1);
        #1;
        chk_idle("t4.done");
        @(negedge clk);

        // len=40 aborted by reset after beat 2
        send_cmd("t5.cmd", 16'd40);
        beat("t5.b1", 64'h0000_0000_0000_0001, 8'hFF, 1'b0);
        beat("t5.b2", 64'h0000_0000_0000_0002, 8'hFF, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 64'h0000_0000_0000_0003;
        #1;
        chk("t5.pre.tvalid", 64'(m_tvalid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_idle("t5.rst");
        chk("t5.rst.tdata",   m_tdata,        64'd0);
        chk("t5.rst.tkeep",   64'(m_tkeep),   64'd0);
        chk("t5.rst.tlast",   64'(m_tlast),   64'd0);
        chk("t5.rst.sready",  64'(s_tready),  64'd0);
        chk("t5.rst.len_err", 64'(len_err),   64'd0);
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        send_cmd("t5.next", 16'd8);
        beat("t5.n1", 64'h7766_5544_3322_1100, 8'hFF, 1'b1);
        #1;
        chk_idle("t5.done");
        @(negedge clk);

`ifdef MSG_TX_LEN_HDR_EN
        send_cmd("t6.cmd", 16'd5);
        beat("t6.b1", 64'h0102_0304_0506_0708, 8'h1F, 1'b1);
        #1;
        chk_idle("t6.done");
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
